// File: rtl/mips_pc_pkg.sv
// Shared encodings and default vectors for the MIPS next-PC logic.
package mips_pc_pkg;

    // Branch condition selector as it arrives from decode.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_op_e;

    // PC sequencing states: free running, stalled with nothing queued,
    // stalled with one redirect target buffered.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation on the rs/rt operands.
// Ordered comparisons (BLEZ/BGTZ/BLTZ/BGEZ) treat rs as two's complement.
module branch_cond_eval
    import mips_pc_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [2:0]    i_br_op,
    input  logic [AW-1:0] i_rs_val,
    input  logic [AW-1:0] i_rt_val,
    output logic          o_taken
);

    logic w_rs_neg;
    logic w_rs_zero;
    logic w_rs_eq_rt;

    assign w_rs_neg   = i_rs_val[AW-1];
    assign w_rs_zero  = (i_rs_val == '0);
    assign w_rs_eq_rt = (i_rs_val == i_rt_val);

    // Select the condition for the decoded branch; reserved code never branches.
    always_comb begin
        o_taken = 1'b0;
        case (br_op_e'(i_br_op))
            BR_BEQ:  o_taken = w_rs_eq_rt;
            BR_BNE:  o_taken = !w_rs_eq_rt;
            BR_BLEZ: o_taken = w_rs_neg || w_rs_zero;
            BR_BGTZ: o_taken = !w_rs_neg && !w_rs_zero;
            BR_BLTZ: o_taken = w_rs_neg;
            BR_BGEZ: o_taken = !w_rs_neg;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Next-PC selection and PC register. Arbitrates exception, JR, J and
// conditional-branch redirects, holds the PC under stall and buffers one
// redirect that arrives while stalled so it is not lost.
module branch_pc_unit
    import mips_pc_pkg::*;
#(
    parameter int            AW           = 32,
    parameter int            IMMW         = 16,
    parameter logic [AW-1:0] RESET_VECTOR = AW'(DEF_RESET_VECTOR),
    parameter logic [AW-1:0] EXC_VECTOR   = AW'(DEF_EXC_VECTOR),
    parameter int            CNTW         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_stall,
    input  logic [2:0]      i_br_op,
    input  logic            i_jump,
    input  logic            i_jr,
    input  logic            i_exc,
    input  logic [IMMW-1:0] i_imm,
    input  logic [25:0]     i_jidx,
    input  logic [AW-1:0]   i_rs_val,
    input  logic [AW-1:0]   i_rt_val,
    output logic [AW-1:0]   o_pc,
    output logic [AW-1:0]   o_pc_plus4,
    output logic            o_redirect,
    output logic            o_addr_err,
    output logic [CNTW-1:0] o_taken_cnt
);

    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_pend;
    logic            r_pend_inc;
    logic            r_pend_err;
    logic            r_redirect;
    logic            r_addr_err;
    logic [CNTW-1:0] r_cnt;
    pc_state_e       r_state;

    logic [AW-1:0]   w_pc_plus4;
    logic [AW-1:0]   w_imm_sext;
    logic [AW-1:0]   w_br_tgt;
    logic [AW-1:0]   w_j_tgt;
    logic            w_taken;
    logic            w_misalign;
    logic [AW-1:0]   w_tgt;
    logic            w_req;
    logic            w_inc;
    logic            w_err;
    logic            w_cnt_sat;

    assign w_pc_plus4 = r_pc + AW'(4);
    assign w_imm_sext = {{(AW-IMMW){i_imm[IMMW-1]}}, i_imm};
    assign w_br_tgt   = w_pc_plus4 + (w_imm_sext << 2);
    assign w_misalign = (i_rs_val[1:0] != 2'b00);
    assign w_cnt_sat  = &r_cnt;

    // Jump target keeps the region bits above the 28-bit index field, if any.
    generate
        if (AW > 28) begin : g_jregion
            assign w_j_tgt = {w_pc_plus4[AW-1:28], i_jidx, 2'b00};
        end else begin : g_jflat
            assign w_j_tgt = {i_jidx, 2'b00};
        end
    endgenerate

    branch_cond_eval #(
        .AW(AW)
    ) u_cond (
        .i_br_op  (i_br_op),
        .i_rs_val (i_rs_val),
        .i_rt_val (i_rt_val),
        .o_taken  (w_taken)
    );

    // Priority target mux: exc > jr > jump > taken branch > sequential.
    // A misaligned JR is steered to the exception vector and not counted.
    always_comb begin
        w_tgt = w_pc_plus4;
        w_req = 1'b0;
        w_inc = 1'b0;
        w_err = 1'b0;
        if (i_exc) begin
            w_tgt = EXC_VECTOR;
            w_req = 1'b1;
        end else if (i_jr) begin
            w_req = 1'b1;
            if (w_misalign) begin
                w_tgt = EXC_VECTOR;
                w_err = 1'b1;
            end else begin
                w_tgt = i_rs_val;
                w_inc = 1'b1;
            end
        end else if (i_jump) begin
            w_tgt = w_j_tgt;
            w_req = 1'b1;
            w_inc = 1'b1;
        end else if (w_taken) begin
            w_tgt = w_br_tgt;
            w_req = 1'b1;
            w_inc = 1'b1;
        end
    end

    // Stall/pend sequencer owning the PC, status pulses and taken counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_pend     <= '0;
            r_pend_inc <= 1'b0;
            r_pend_err <= 1'b0;
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_RUN;
        end else begin
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                S_RUN, S_HOLD: begin
                    if (!i_stall) begin
                        r_pc       <= w_tgt;
                        r_redirect <= w_req;
                        r_addr_err <= w_err;
                        if (w_inc && !w_cnt_sat) begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                        r_state <= S_RUN;
                    end else if (w_req) begin
                        r_pend     <= w_tgt;
                        r_pend_inc <= w_inc;
                        r_pend_err <= w_err;
                        r_state    <= S_PEND;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_PEND: begin
                    if (!i_stall) begin
                        // Release the buffered redirect; this cycle's inputs are dropped.
                        r_pc       <= r_pend;
                        r_redirect <= 1'b1;
                        r_addr_err <= r_pend_err;
                        if (r_pend_inc && !w_cnt_sat) begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                        r_pend     <= '0;
                        r_pend_inc <= 1'b0;
                        r_pend_err <= 1'b0;
                        r_state    <= S_RUN;
                    end else if (i_exc) begin
                        // Only an exception may displace an already buffered target.
                        r_pend     <= EXC_VECTOR;
                        r_pend_inc <= 1'b0;
                        r_pend_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_plus4  = w_pc_plus4;
    assign o_redirect  = r_redirect;
    assign o_addr_err  = r_addr_err;
    assign o_taken_cnt = r_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a table of single-cycle vectors followed
// by hand-written stall / pend / reset sequences. A second instance with a
// 2-bit counter checks saturation against the same stimulus.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  br_op;
    logic        jump;
    logic        jr;
    logic        exc;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    logic [31:0] pc, pc_plus4;
    logic        redirect, addr_err;
    logic [15:0] taken_cnt;

    logic [31:0] pc2, pc_plus4_2;
    logic        redirect2, addr_err2;
    logic [1:0]  taken_cnt2;

    int n_pass  = 0;
    int n_total = 0;

    branch_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_br_op(br_op),
        .i_jump(jump), .i_jr(jr), .i_exc(exc), .i_imm(imm), .i_jidx(jidx),
        .i_rs_val(rs_val), .i_rt_val(rt_val),
        .o_pc(pc), .o_pc_plus4(pc_plus4), .o_redirect(redirect),
        .o_addr_err(addr_err), .o_taken_cnt(taken_cnt)
    );

    branch_pc_unit #(.CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_br_op(br_op),
        .i_jump(jump), .i_jr(jr), .i_exc(exc), .i_imm(imm), .i_jidx(jidx),
        .i_rs_val(rs_val), .i_rt_val(rt_val),
        .o_pc(pc2), .o_pc_plus4(pc_plus4_2), .o_redirect(redirect2),
        .o_addr_err(addr_err2), .o_taken_cnt(taken_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic        j;
        logic        r;
        logic        e;
        logic [15:0] im;
        logic [25:0] ji;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_pc;
        logic        exp_rd;
        logic        exp_ae;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic av(input logic [2:0] op, input logic j, input logic r, input logic e,
                      input logic [15:0] im, input logic [25:0] ji,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] ep, input logic erd, input logic eae,
                      input logic [15:0] ec);
        vec_t v;
        v.st = 1'b0; v.op = op; v.j = j; v.r = r; v.e = e; v.im = im; v.ji = ji;
        v.rs = rs; v.rt = rt; v.exp_pc = ep; v.exp_rd = erd; v.exp_ae = eae; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_state(input string nm, input logic [31:0] ep, input logic erd,
                             input logic eae, input logic [15:0] ec);
        logic [1:0] ec2;
        ec2 = (ec > 16'd3) ? 2'd3 : ec[1:0];
        chk({nm, ".pc"},       pc,                  ep);
        chk({nm, ".pc_plus4"}, pc_plus4,            ep + 32'd4);
        chk({nm, ".redirect"}, {31'd0, redirect},   {31'd0, erd});
        chk({nm, ".addr_err"}, {31'd0, addr_err},   {31'd0, eae});
        chk({nm, ".cnt"},      {16'd0, taken_cnt},  {16'd0, ec});
        chk({nm, ".cnt_sat"},  {30'd0, taken_cnt2}, {30'd0, ec2});
    endtask

    task automatic drive(input logic st, input logic [2:0] op, input logic j, input logic r,
                         input logic e, input logic [15:0] im, input logic [25:0] ji,
                         input logic [31:0] rs, input logic [31:0] rt);
        stall = st; br_op = op; jump = j; jr = r; exc = e;
        imm = im; jidx = ji; rs_val = rs; rt_val = rt;
    endtask

    task automatic idle(input logic st);
        drive(st, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle(1'b0);

        // Reset asserted asynchronously between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk_state("reset", 32'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        //  op    j    r    e    imm      jidx   rs            rt            exp_pc        rd   ae   cnt
        av(3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0,        32'h0, 32'h0000_0004, 1'b0, 1'b0, 16'd0);
        av(3'd1, 1'b0, 1'b0, 1'b0, 16'h0011, 26'h0, 32'h5,        32'h5, 32'h0000_004C, 1'b1, 1'b0, 16'd1);
        av(3'd1, 1'b0, 1'b0, 1'b0, 16'h0011, 26'h0, 32'h5,        32'h6, 32'h0000_0050, 1'b0, 1'b0, 16'd1);
        av(3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h0, 32'h100,      32'h0, 32'h0000_0100, 1'b1, 1'b0, 16'd2);
        av(3'd2, 1'b0, 1'b0, 1'b0, 16'hFFFF, 26'h0, 32'h1,        32'h2, 32'h0000_0100, 1'b1, 1'b0, 16'd3);
        av(3'd3, 1'b0, 1'b0, 1'b0, 16'h0004, 26'h0, 32'h0,        32'h0, 32'h0000_0114, 1'b1, 1'b0, 16'd4);
        av(3'd3, 1'b0, 1'b0, 1'b0, 16'h0004, 26'h0, 32'h1,        32'h0, 32'h0000_0118, 1'b0, 1'b0, 16'd4);
        av(3'd4, 1'b0, 1'b0, 1'b0, 16'h0004, 26'h0, 32'h8000_0000, 32'h0, 32'h0000_011C, 1'b0, 1'b0, 16'd4);
        av(3'd4, 1'b0, 1'b0, 1'b0, 16'h0002, 26'h0, 32'h1,        32'h0, 32'h0000_0128, 1'b1, 1'b0, 16'd5);
        av(3'd5, 1'b0, 1'b0, 1'b0, 16'h0001, 26'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0130, 1'b1, 1'b0, 16'd6);
        av(3'd5, 1'b0, 1'b0, 1'b0, 16'h0001, 26'h0, 32'h0,        32'h0, 32'h0000_0134, 1'b0, 1'b0, 16'd6);
        av(3'd6, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0,        32'h0, 32'h0000_0130, 1'b1, 1'b0, 16'd7);
        av(3'd6, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'hFFFF_FFFE, 32'h0, 32'h0000_0134, 1'b0, 1'b0, 16'd7);
        av(3'd7, 1'b0, 1'b0, 1'b0, 16'h0010, 26'h0, 32'h0,        32'h0, 32'h0000_0138, 1'b0, 1'b0, 16'd7);
        av(3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h40, 32'h0,       32'h0, 32'h0000_0100, 1'b1, 1'b0, 16'd8);
        av(3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 26'h40, 32'h2000,    32'h0, 32'h0000_2000, 1'b1, 1'b0, 16'd9);
        av(3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h0, 32'h202,      32'h0, 32'h0000_0080, 1'b1, 1'b1, 16'd9);
        av(3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0,        32'h0, 32'h0000_0084, 1'b0, 1'b0, 16'd9);
        av(3'd1, 1'b1, 1'b1, 1'b1, 16'h0010, 26'h40, 32'h300,     32'h300, 32'h0000_0080, 1'b1, 1'b0, 16'd9);
        av(3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 16'd10);
        av(3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0,        32'h0, 32'h0000_0000, 1'b0, 1'b0, 16'd10);

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].op, vecs[i].j, vecs[i].r, vecs[i].e,
                  vecs[i].im, vecs[i].ji, vecs[i].rs, vecs[i].rt);
            tick();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_rd,
                      vecs[i].exp_ae, vecs[i].exp_cnt);
        end

        // Jump buffered under a three-cycle stall; a later jump is ignored.
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0, 32'h1000, 32'h0);
        tick(); chk_state("setpc", 32'h1000, 1'b1, 1'b0, 16'd11);
        drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h40, 32'h0, 32'h0);
        tick(); chk_state("stall1", 32'h1000, 1'b0, 1'b0, 16'd11);
        drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h80, 32'h0, 32'h0);
        tick(); chk_state("stall2", 32'h1000, 1'b0, 1'b0, 16'd11);
        tick(); chk_state("stall3", 32'h1000, 1'b0, 1'b0, 16'd11);
        idle(1'b0);
        tick(); chk_state("release", 32'h0000_0100, 1'b1, 1'b0, 16'd12);
        tick(); chk_state("after_rel", 32'h0000_0104, 1'b0, 1'b0, 16'd12);

        // Exception overwrites a buffered taken branch and is not counted.
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 16'h1, 26'h0, 32'h7, 32'h7);
        tick(); chk_state("pend_br", 32'h0000_0104, 1'b0, 1'b0, 16'd12);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0, 32'h0);
        tick(); chk_state("pend_exc", 32'h0000_0104, 1'b0, 1'b0, 16'd12);
        idle(1'b0);
        tick(); chk_state("exc_rel", 32'h0000_0080, 1'b1, 1'b0, 16'd12);
        tick(); chk_state("exc_after", 32'h0000_0084, 1'b0, 1'b0, 16'd12);

        // Stall with nothing queued, then a jump applied on the release cycle.
        idle(1'b1);
        tick(); chk_state("hold1", 32'h0000_0084, 1'b0, 1'b0, 16'd12);
        tick(); chk_state("hold2", 32'h0000_0084, 1'b0, 1'b0, 16'd12);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h10, 32'h0, 32'h0);
        tick(); chk_state("hold_rel", 32'h0000_0040, 1'b1, 1'b0, 16'd13);

        // Misaligned JR buffered while stalled reports addr_err on release.
        drive(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0, 32'h202, 32'h0);
        tick(); chk_state("pend_jr", 32'h0000_0040, 1'b0, 1'b0, 16'd13);
        idle(1'b0);
        tick(); chk_state("jr_rel", 32'h0000_0080, 1'b1, 1'b1, 16'd13);
        tick(); chk_state("jr_after", 32'h0000_0084, 1'b0, 1'b0, 16'd13);

        // Asynchronous reset while a redirect is pending discards it.
        drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h40, 32'h0, 32'h0);
        tick(); chk_state("pend_j", 32'h0000_0084, 1'b0, 1'b0, 16'd13);
        #2 rst_n = 1'b0;
        #1 chk_state("rst_pend", 32'h0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        idle(1'b0);
        tick(); chk_state("post_rst", 32'h0000_0004, 1'b0, 1'b0, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
